apb_regbank_slave: RTL and testbench

APB4 completer that terminates the APB side of the AHB-to-APB bridge: it consumes the PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT transfers the bridge issues and answers with PREADY/PRDATA/PSLVERR. It holds a small bank of 32-bit registers, inserts a programmable number of wait states, and flags decode, permission and read-only violations with PSLVERR. It is the synthesizable counterpart to the behavioural slave model and is the DUT-side sink for bridge integration tests.

---
 rtl/apb_regbank_slave.sv | 160 ++++++++++++++++
 tb/tb_apb_regbank_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | apb_regbank_slave : APB4 completer with CTRL/STATUS/GP register bank     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module apb_regbank_slave #(
  parameter int PDATA_SIZE   = 32,
  parameter int NUM_REGS     = 16,
  parameter int DEFAULT_WAIT = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int c_IDX_W  = $clog2(NUM_REGS);
  localparam int c_AIDX_W = PDATA_SIZE - 2;
  localparam int c_STRB_W = PDATA_SIZE / 8;

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_ACCESS = 1'b1;

  logic [0:0]            r_state;
  logic [3:0]            r_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic                  r_write;
  logic [PDATA_SIZE-1:0] r_wdata;
  logic [c_STRB_W-1:0]   r_strb;
  logic                  r_err;

  logic [3:0]            r_wait;
  logic [15:0]           r_ok_cnt;
  logic [15:0]           r_err_cnt;
  logic [PDATA_SIZE-1:0] r_gp [2:NUM_REGS-1];

  logic [c_AIDX_W-1:0]   w_addr_idx;
  logic                  w_cap_err;
  logic                  w_setup;
  logic                  w_last;
  logic                  w_commit;
  logic                  w_wr_en;
  logic [PDATA_SIZE-1:0] w_rd_word;
  logic                  w_unused;

  assign w_addr_idx = PADDR[PDATA_SIZE-1:2];

  // Decode/permission error is frozen at setup so the response never depends on
  // what the bridge leaves on PADDR during the access phase.
  assign w_cap_err = (w_addr_idx >= c_AIDX_W'(NUM_REGS))
                   || (PWRITE && (w_addr_idx == c_AIDX_W'(1)))
                   || (PWRITE && (w_addr_idx == '0) && !PPROT[0]);

  assign w_setup  = (r_state == c_ST_IDLE) && PSEL && !PENABLE;
  assign w_last   = (r_state == c_ST_ACCESS) && (r_cnt == 4'd0);
  assign w_commit = w_last && PSEL;
  assign w_wr_en  = w_commit && r_write && !r_err;

  assign w_unused = ^{PPROT[2:1], PADDR[1:0]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_setup) begin
            r_state <= c_ST_ACCESS;
            r_cnt   <= r_wait;
            r_idx   <= w_addr_idx[c_IDX_W-1:0];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
            r_err   <= w_cap_err;
          end
        end
        c_ST_ACCESS: begin
          if (!PSEL) begin
            r_state <= c_ST_IDLE;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ok_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
    end else if (w_commit) begin
      if (r_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait <= 4'(DEFAULT_WAIT);
    end else if (w_wr_en && (r_idx == '0) && r_strb[0]) begin
      r_wait <= r_wdata[3:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 2; i < NUM_REGS; i++) r_gp[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (r_idx == c_IDX_W'(i)) begin
          for (int b = 0; b < c_STRB_W; b++) begin
            if (r_strb[b]) r_gp[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (r_idx == c_IDX_W'(0)) begin
      w_rd_word[3:0] = r_wait;
    end else if (r_idx == c_IDX_W'(1)) begin
      w_rd_word[15:0]  = r_ok_cnt;
      w_rd_word[31:16] = r_err_cnt;
    end else begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (r_idx == c_IDX_W'(i)) w_rd_word = r_gp[i];
      end
    end
  end

  assign PREADY  = w_last;
  assign PSLVERR = w_last && r_err;
  assign PRDATA  = (w_last && !r_write && !r_err) ? w_rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_apb_regbank_slave : scoreboard bench for the APB register bank        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_apb_regbank_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_regbank_slave #(.PDATA_SIZE(32), .NUM_REGS(16), .DEFAULT_WAIT(1)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          len;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_gp [16];
  logic [3:0]  m_wait;
  logic [15:0] m_ok, m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 4'd1;
    m_ok   = 16'd0;
    m_err  = 16'd0;
    for (int i = 0; i < 16; i++) m_gp[i] = 32'd0;
  endtask

  function automatic logic [31:0] mread(input int idx);
    if (idx == 0) return {28'd0, m_wait};
    if (idx == 1) return {m_err, m_ok};
    return m_gp[idx];
  endfunction

  // Entered and left at posedge+1; consecutive calls are back-to-back.
  task automatic xfer(input string tag, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
    exp_t e, o;
    int   idx;
    int   cyc;
    logic rdy;
    idx     = int'(addr[31:2]);
    e.err   = (addr[31:2] >= 30'd16) || (w && idx == 1) || (w && idx == 0 && !prot[0]);
    e.rdata = (!w && !e.err) ? mread(idx) : 32'd0;
    e.len   = int'(m_wait) + 2;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot;
    sb_q.push_back(e);
    @(negedge PCLK);
    chk($sformatf("%s/setup_out", tag), {PREADY, PSLVERR, PRDATA}, 64'd0);
    @(posedge PCLK); #1 PENABLE = 1'b1;
    cyc = 1; rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      @(negedge PCLK);
      if (PREADY) rdy = 1'b1;
      else begin @(posedge PCLK); #1; cyc++; end
    end
    o = sb_q.pop_front();
    if (!rdy) begin
      chk($sformatf("%s/timeout", tag), 64'd0, 64'd1);
    end else begin
      chk($sformatf("%s/len", tag), cyc + 1, o.len);
      chk($sformatf("%s/slverr", tag), PSLVERR, o.err);
      chk($sformatf("%s/rdata", tag), PRDATA, o.rdata);
    end
    if (o.err) begin
      if (m_err != 16'hFFFF) m_err++;
    end else begin
      m_ok++;
      if (w && idx == 0 && strb[0]) m_wait = data[3:0];
      if (w && idx >= 2)
        for (int b = 0; b < 4; b++) if (strb[b]) m_gp[idx][8*b +: 8] = data[8*b +: 8];
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr;
    PWDATA = data; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); chk("abort/t1_ready", PREADY, 1'b0);
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); chk("abort/t2_ready", PREADY, 1'b0);
    @(posedge PCLK); #1;
    @(negedge PCLK); chk("abort/after_ready", PREADY, 1'b0);
    @(posedge PCLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    model_reset();
    idle(3);
    chk("reset/outputs", {PREADY, PSLVERR, PRDATA}, 64'd0);
    PRESET = 1'b0;
    idle(1);

    // reset defaults
    xfer("rd_ctrl_rst",   1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
    xfer("rd_status_rst", 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer("rd_gp2_rst",    1'b0, 32'h08, 32'h0, 4'h0, 3'b000);

    // byte strobes
    xfer("wr_gp2_full",   1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 3'b000);
    xfer("wr_gp2_strb5",  1'b1, 32'h08, 32'h11223344, 4'h5, 3'b000);
    xfer("rd_gp2_merge",  1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    xfer("rd_status_ok",  1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    idle(2);

    // wait states
    xfer("wr_ctrl_0",     1'b1, 32'h00, 32'h0, 4'hF, 3'b001);
    xfer("wr_ctrl_4",     1'b1, 32'h00, 32'h4, 4'hF, 3'b001);
    xfer("rd_gp2_w4",     1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    xfer("wr_ctrl_nob0",  1'b1, 32'h00, 32'hF, 4'h2, 3'b001);
    xfer("rd_ctrl_w4",    1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
    xfer("wr_ctrl_0b",    1'b1, 32'h00, 32'h0, 4'h1, 3'b001);
    xfer("rd_gp2_w0",     1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
    xfer("wr_gp15",       1'b1, 32'h3C, 32'hDEADBEEF, 4'hF, 3'b000);
    xfer("rd_gp15",       1'b0, 32'h3F, 32'h0, 4'h0, 3'b000);
    idle(1);

    // errors
    xfer("rd_oob",        1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    xfer("wr_status",     1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 3'b001);
    xfer("wr_ctrl_unpriv",1'b1, 32'h00, 32'h7, 4'hF, 3'b000);
    xfer("rd_ctrl_keep",  1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
    xfer("rd_status_err", 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);

    // abort with WAIT=3
    xfer("wr_ctrl_3",     1'b1, 32'h00, 32'hFFFFFFF3, 4'hF, 3'b001);
    xfer("rd_ctrl_3",     1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
    abort_xfer(32'h0C, 32'h5A5A5A5A);
    xfer("rd_gp3_abort",  1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    xfer("rd_status_ab",  1'b0, 32'h04, 32'h0, 4'h0, 3'b000);

    // reset in T2 of a write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C;
    PWDATA = 32'h5A5A5A5A; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b1;
    #1 chk("rst_mid/outputs", {PREADY, PSLVERR, PRDATA}, 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    idle(1);
    PRESET = 1'b0;
    xfer("rd_gp3_rst",    1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
    xfer("rd_status_rst2",1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer("rd_ctrl_rst2",  1'b0, 32'h00, 32'h0, 4'h0, 3'b000);

    // reset during a completion cycle drops outputs immediately
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h00; PPROT = 3'b000;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #2;
    chk("rst_done/pre", {PREADY, PSLVERR, PRDATA}, {1'b1, 1'b0, 32'h1});
    PRESET = 1'b1;
    #1 chk("rst_done/outputs", {PREADY, PSLVERR, PRDATA}, 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    idle(1);
    PRESET = 1'b0;
    xfer("wr_ctrl_fast",  1'b1, 32'h00, 32'h0, 4'hF, 3'b001);

    // OK_CNT wrap: preload near the top instead of 65536 transfers
    @(negedge PCLK);
    force dut.r_ok_cnt = 16'hFFFE;
    #1 release dut.r_ok_cnt;
    m_ok = 16'hFFFE;
    @(posedge PCLK); #1;
    xfer("wrap_wr",       1'b1, 32'h10, 32'h12345678, 4'hF, 3'b000);
    xfer("wrap_st_top",   1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer("wrap_st_zero",  1'b0, 32'h04, 32'h0, 4'h0, 3'b000);

    // ERR_CNT saturation
    @(negedge PCLK);
    force dut.r_err_cnt = 16'hFFFE;
    #1 release dut.r_err_cnt;
    m_err = 16'hFFFE;
    @(posedge PCLK); #1;
    xfer("sat_err1",      1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    xfer("sat_err2",      1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
    xfer("sat_st_top",    1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer("sat_err3",      1'b1, 32'h04, 32'h0, 4'hF, 3'b001);
    xfer("sat_st_hold",   1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer("rd_gp4",        1'b0, 32'h10, 32'h0, 4'h0, 3'b000);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
